apb_spi_regif: RTL and testbench
================================

# apb_spi_regif

APB completer (slave) register interface sitting between the APB bus and the SPI SRAM engine. It decodes four word registers (command, status, write data, read data), buffers write and read data in two FIFOs, and hands commands and data to the engine over valid/ready streams. Full/empty conditions insert APB wait states by holding `pready` low; there is no bus error response.

## Interface
- `DEPTH`, default 8: entries per FIFO. Must be a power of 2, at least 2.
- `CW`, default 4: count width, equal to log2(DEPTH)+1.
- `clk` in 1: clock; APB `pclk` is this same clock.
- `rst` in 1: synchronous, active-high reset.
- `paddr` in 32: word address; only 0..3 are decoded.
- `pwrite` in 1: 1 = write, 0 = read.
- `psel` in 1: select.
- `pen` in 1: enable (ACCESS phase).
- `pwdata` in 32: write data.
- `prdata` out 32: read data; valid while `psel & pen & pready`.
- `pready` out 1: access completes on an edge where `psel & pen & pready`.
- `cmd` out 32: last command written.
- `cmd_valid` out 1: command pending toward the engine.
- `cmd_ready` in 1: engine accepts the command.
- `tx_data` out 32: TX FIFO head.
- `tx_valid` out 1: TX FIFO not empty.
- `tx_ready` in 1: engine pops TX.
- `rx_data` in 32: engine read data.
- `rx_valid` in 1: engine pushes RX.
- `rx_ready` out 1: RX FIFO not full.
- `busy` in 1: engine transaction in progress.

## Operation
- Decode: `paddr == 0` CMD, `1` STATUS, `2` TXDATA, `3` RXDATA. Any other address: `pready` = 1, read returns 0, write is ignored.
- CMD write: `cmd <= pwdata`, `cmd_valid <= 1`. The write stalls while `cmd_valid` is already 1. `cmd_valid` clears on `cmd_valid & cmd_ready`. CMD read returns `cmd`, never stalls.
- STATUS read, never stalls, fields:
  - [0] `busy | cmd_valid`
  - [1] tx_full
  - [2] tx_empty
  - [3] rx_full
  - [4] rx_empty
  - [5] timeout sticky (macro builds only, else 0)
  - [8+:CW] tx count
  - [16+:CW] rx count
  - other bits 0
  - STATUS writes are ignored and do not stall.
- TXDATA write: pushes `pwdata`; stalls while tx_full. TXDATA read returns 0, no stall.
- RXDATA read: returns the RX head and pops it; stalls while rx_empty. RXDATA write is ignored, no stall.
- FIFOs: circular, with read/write pointers of log2(DEPTH) bits that wrap, plus a CW-bit count. Push and pop in the same cycle leave the count unchanged. Full/empty are evaluated from the current registered count only. A simultaneous engine pop therefore does not unblock a stalled push in that same cycle.
- Side effects (push, pop, cmd latch) happen only on the completing edge. They happen exactly once per access, regardless of the number of wait cycles.

## Timing
- `pready` and `prdata` are combinational from registered state and the current APB inputs. A non-stalled access completes in its first ACCESS cycle: SETUP plus ACCESS, 2 cycles total.
- `pready` is 0 outside ACCESS and while `rst` = 1.
- Stall release: condition clears on edge N, so `pready` rises in cycle N+1 and the access completes at the end of that cycle.
- Engine latency:
  - TX data pushed on edge N is visible on `tx_valid`/`tx_data` in cycle N+1.
  - RX data pushed on edge N is readable via RXDATA from cycle N+1.
  - A command written on edge N drives `cmd_valid` from cycle N+1.
- Reset values: `prdata` 0, `pready` 0, `cmd` 0, `cmd_valid` 0, `tx_valid` 0, both FIFOs empty, counts 0, timeout sticky 0. `rx_ready` is 0 during reset and 1 from the first cycle after.
- Reset mid-access or mid-stall: the access is abandoned with no side effect, and FIFO contents are discarded.

## Configuration
- `APB_STALL_TIMEOUT_EN` defined:
  - An 8-bit counter runs while `psel & pen & ~pready` due to a stall.
  - The counter clears on any completion and whenever `psel` = 0.
  - On the 256th consecutive stall cycle, `pready` = 1 that cycle and the access completes with no side effect: write dropped, read returns 32'hDEAD_BEEF.
  - STATUS[5] is set on that timeout and cleared by a completed STATUS read (the read returns 1).
- Not defined: stalls are unbounded, there is no counter, and STATUS[5] reads 0.

## Test plan
- Reset, then STATUS read -> 32'h0000_0014 (tx_empty, rx_empty), completes in 2 cycles; `rx_ready` = 1, `cmd_valid` = 0.
- Write CMD 32'h188 with `cmd_ready` = 0, then second CMD write 32'h108 -> second access stalls; raise `cmd_ready` for 1 cycle -> stall releases next cycle, `cmd` = 32'h108, `cmd_valid` = 1.
- 8 TXDATA writes 3,4,5,6,... with `tx_ready` = 0 -> STATUS [1] = 1, tx count = 8; 9th write stalls; one engine pop -> 9th completes; pops then observe 3,4,5,6,... in order across pointer wrap.
- RXDATA read with empty RX -> stalls; `rx_valid` with data 32'h100 on edge N -> read completes in cycle N+1 returning 32'h100, and rx count returns to 0.
- Simultaneous engine push and APB RXDATA pop at rx count 4 -> count stays 4 and data order is preserved; paddr 32'h10 read -> 0, no stall.
- With `APB_STALL_TIMEOUT_EN`: RXDATA read on empty RX held for 256 cycles -> completes with 32'hDEAD_BEEF; next STATUS read shows bit5 = 1, and the following STATUS read shows bit5 = 0.

Source files
------------

// File: rtl/apb_spi_regif.sv
// APB register front end for the SPI SRAM engine: CMD/STATUS/TXDATA/RXDATA
// decode, TX/RX FIFOs, wait-state insertion. Option: APB_STALL_TIMEOUT_EN.
module apb_spi_regif #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        pen,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic [31:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        busy
);

    localparam int AW = $clog2(DEPTH);

    logic          access;
    logic          sel_cmd, sel_stat, sel_tx, sel_rx;
    logic          stall, done, effect;
    logic          timeout_hit, timeout_flag;
    logic [31:0]   status;

    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(DEPTH));
    assign rx_empty = (rx_cnt == '0);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rp];
    assign rx_ready = ~rst & ~rx_full;

    // Address decode, stall detection and completion qualifiers
    always_comb begin
        access   = psel & pen;
        sel_cmd  = (paddr == 32'd0);
        sel_stat = (paddr == 32'd1);
        sel_tx   = (paddr == 32'd2);
        sel_rx   = (paddr == 32'd3);
        stall    = access & ((sel_cmd & pwrite & cmd_valid)
                           | (sel_tx & pwrite & tx_full)
                           | (sel_rx & ~pwrite & rx_empty));
        pready   = ~rst & access & (~stall | timeout_hit);
        done     = access & pready;
        effect   = done & ~stall;
        tx_push  = effect & sel_tx & pwrite;
        rx_pop   = effect & sel_rx & ~pwrite;
        tx_pop   = tx_valid & tx_ready;
        rx_push  = rx_valid & rx_ready;
    end

    // STATUS word assembly
    always_comb begin
        status          = '0;
        status[0]       = busy | cmd_valid;
        status[1]       = tx_full;
        status[2]       = tx_empty;
        status[3]       = rx_full;
        status[4]       = rx_empty;
        status[5]       = timeout_flag;
        status[8+:CW]   = tx_cnt;
        status[16+:CW]  = rx_cnt;
    end

    // Read data mux, only driven on a completing read
    always_comb begin
        prdata = '0;
        if (done & ~pwrite) begin
            if (timeout_hit) begin
                prdata = 32'hDEAD_BEEF;
            end else begin
                unique case (1'b1)
                    sel_cmd:  prdata = cmd;
                    sel_stat: prdata = status;
                    sel_rx:   prdata = rx_mem[rx_rp];
                    default:  prdata = '0;
                endcase
            end
        end
    end

    // Command latch and handoff to the engine
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else if (effect & sel_cmd & pwrite) begin
            cmd       <= pwdata;
            cmd_valid <= 1'b1;
        end else if (cmd_valid & cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // TX FIFO storage (contents need no reset; count gates visibility)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= pwdata;
    end

    // TX FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    // RX FIFO pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

`ifdef APB_STALL_TIMEOUT_EN
    logic [7:0] stall_cnt;

    // A stall in its 256th consecutive cycle is forced to complete
    assign timeout_hit = stall & (stall_cnt == 8'hFF);

    // Consecutive stall cycle counter
    always_ff @(posedge clk) begin
        if (rst | ~psel | done) stall_cnt <= '0;
        else if (stall)         stall_cnt <= stall_cnt + 1'b1;
    end

    // Sticky timeout flag, cleared by reading STATUS
    always_ff @(posedge clk) begin
        if (rst)                               timeout_flag <= 1'b0;
        else if (done & timeout_hit)           timeout_flag <= 1'b1;
        else if (effect & sel_stat & ~pwrite)  timeout_flag <= 1'b0;
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_apb_spi_regif.sv
// Self-checking bench for apb_spi_regif: vector table for plain accesses,
// scoreboard queues for FIFO data, hand sequences for stalls.
module tb_apb_spi_regif;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic        psel = 1'b0;
    logic        pen = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        busy = 1'b0;

    int errs = 0;
    int nchk = 0;
    localparam int LIMIT = 400;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];

    apb_spi_regif #(.DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite),
        .psel(psel), .pen(pen), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One APB access; waits = ACCESS cycles with pready low
    task automatic apb(input logic [31:0] a, input logic w,
                       input logic [31:0] d, output logic [31:0] rd,
                       output int waits);
        rd = '0;
        waits = 0;
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        pen = 1'b1;
        while (1) begin
            @(negedge clk);
            if (pready) begin
                rd = prdata;
                break;
            end
            waits++;
            if (waits >= LIMIT) begin
                nchk++;
                errs++;
                $display("FAIL apb_timeout: addr %h no pready after %0d",
                         a, waits);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
    endtask

    logic [31:0] rd;
    int          w;

    initial begin
        vt[0] = '{32'd1,  1'b0, 32'h0,        32'h0000_0014};
        vt[1] = '{32'd0,  1'b0, 32'h0,        32'h0};
        vt[2] = '{32'd2,  1'b0, 32'h0,        32'h0};
        vt[3] = '{32'h10, 1'b0, 32'h0,        32'h0};
        vt[4] = '{32'h10, 1'b1, 32'h1234_5678, 32'h0};
        vt[5] = '{32'd1,  1'b1, 32'hFFFF_FFFF, 32'h0};
        vt[6] = '{32'd3,  1'b1, 32'hAAAA_5555, 32'h0};
        vt[7] = '{32'd1,  1'b0, 32'h0,        32'h0000_0014};

        // reset behaviour, with an access attempted during reset
        @(posedge clk); #1;
        psel = 1'b1; pen = 1'b1; paddr = 32'd1;
        @(negedge clk);
        check("rst_pready", {31'b0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rx_ready_after_rst", {31'b0, rx_ready}, 32'd1);
        check("cmd_valid_reset", {31'b0, cmd_valid}, 32'd0);
        check("tx_valid_reset", {31'b0, tx_valid}, 32'd0);
        check("cmd_reset", cmd, 32'd0);

        // plain non-stalling accesses
        for (int i = 0; i < 8; i++) begin
            apb(vt[i].addr, vt[i].wr, vt[i].wdata, rd, w);
            if (!vt[i].wr) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
            check($sformatf("vec%0d_waits", i), w, 32'd0);
        end

        // command handoff and CMD stall
        apb(32'd0, 1'b1, 32'h188, rd, w);
        check("cmd1_waits", w, 32'd0);
        check("cmd1_value", cmd, 32'h188);
        check("cmd1_valid", {31'b0, cmd_valid}, 32'd1);
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_cmd_pending", rd, 32'h0000_0015);
        apb(32'd0, 1'b0, 32'h0, rd, w);
        check("cmd_readback", rd, 32'h188);
        fork
            apb(32'd0, 1'b1, 32'h108, rd, w);
            begin
                repeat (3) @(posedge clk);
                #1 cmd_ready = 1'b1;
                @(posedge clk);
                #1 cmd_ready = 1'b0;
            end
        join
        check("cmd2_waits", w, 32'd2);
        check("cmd2_value", cmd, 32'h108);
        check("cmd2_valid", {31'b0, cmd_valid}, 32'd1);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        check("cmd_drained", {31'b0, cmd_valid}, 32'd0);

        // fill TX, stall on full, engine pop, drain across wrap
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(32'(i + 3));
            apb(32'd2, 1'b1, 32'(i + 3), rd, w);
            check($sformatf("tx_wr%0d_waits", i), w, 32'd0);
        end
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_tx_full", rd, 32'h0000_0812);
        tx_q.push_back(32'd11);
        fork
            apb(32'd2, 1'b1, 32'd11, rd, w);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("tx_pop_first", tx_data, tx_q.pop_front());
                tx_ready = 1'b1;
                @(posedge clk);
                #1 tx_ready = 1'b0;
            end
        join
        check("tx_full_release_waits", w, 32'd2);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_valid%0d", i), {31'b0, tx_valid}, 32'd1);
            check($sformatf("tx_pop%0d", i), tx_data, tx_q.pop_front());
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        check("tx_empty_after_drain", {31'b0, tx_valid}, 32'd0);

        // RXDATA read on empty RX stalls until the engine pushes
        fork
            apb(32'd3, 1'b0, 32'h0, rd, w);
            begin
                repeat (3) @(posedge clk);
                #1;
                rx_data = 32'h100; rx_valid = 1'b1;
                rx_q.push_back(32'h100);
                @(posedge clk);
                #1 rx_valid = 1'b0;
            end
        join
        check("rx_stall_waits", w, 32'd2);
        check("rx_stall_data", rd, rx_q.pop_front());
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_rx_back_empty", rd, 32'h0000_0014);

        // RX at count 4, simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            rx_data = 32'h200 + 32'(i); rx_valid = 1'b1;
            rx_q.push_back(32'h200 + 32'(i));
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_rx4", rd, 32'h0004_0004);
        fork
            apb(32'd3, 1'b0, 32'h0, rd, w);
            begin
                repeat (2) @(posedge clk);
                #1;
                rx_data = 32'h300; rx_valid = 1'b1;
                rx_q.push_back(32'h300);
                @(posedge clk);
                #1 rx_valid = 1'b0;
            end
        join
        check("rx_simul_data", rd, rx_q.pop_front());
        check("rx_simul_waits", w, 32'd0);
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_rx_still4", rd, 32'h0004_0004);
        for (int i = 0; i < 4; i++) begin
            apb(32'd3, 1'b0, 32'h0, rd, w);
            check($sformatf("rx_drain%0d", i), rd, rx_q.pop_front());
        end
        apb(32'h10, 1'b0, 32'h0, rd, w);
        check("unmapped_rd", rd, 32'h0);
        check("unmapped_waits", w, 32'd0);

`ifdef APB_STALL_TIMEOUT_EN
        apb(32'd3, 1'b0, 32'h0, rd, w);
        check("timeout_data", rd, 32'hDEAD_BEEF);
        check("timeout_waits", w, 32'd255);
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_timeout_set", rd, 32'h0000_0034);
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_timeout_clr", rd, 32'h0000_0014);
`endif

        // reset discards FIFO contents
        apb(32'd2, 1'b1, 32'h55, rd, w);
        apb(32'd2, 1'b1, 32'h66, rd, w);
        check("tx_valid_before_rst", {31'b0, tx_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("tx_valid_after_rst", {31'b0, tx_valid}, 32'd0);
        apb(32'd1, 1'b0, 32'h0, rd, w);
        check("status_after_rst", rd, 32'h0000_0014);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
